// File: rtl/mux_arb_n_w_pkg.sv
// Shared constants for the N-channel registered mux/arbiter.
package mux_arb_n_w_pkg;
   localparam logic MODE_FIXED   = 1'b0;
   localparam logic MODE_RR      = 1'b1;
   localparam int   MAX_CHANNELS = 16;
endpackage

// File: rtl/mux_arb_n_w_rr.sv
// Round-robin arbiter: the first requester strictly after ptr wins, wrapping at CHANNELS-1.
module rr_arbiter #(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic [SEL_W-1:0]    gnt_idx,
   output logic                any_gnt
);
   int idx;

   // Scan from the farthest candidate back to ptr+1 so the nearest one is written last.
   always_comb begin
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = 0;
      for (int k = CHANNELS; k >= 1; k--) begin
         idx = (int'(ptr) + k) % CHANNELS;
         if (req[idx]) begin
            gnt_idx = SEL_W'(idx);
            any_gnt = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux_arb_n_w.sv
// N-channel W-bit registered mux with fixed-select or round-robin grant and a tri-state output.
module mux_arb_n_w
   import mux_arb_n_w_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic [CHANNELS-1:0]       valid_in,
   output logic [CHANNELS-1:0]       ready_out,
   input  logic [SEL_W-1:0]          select,
   input  logic                      arb_mode,
   input  logic                      enable,
   output logic [WIDTH-1:0]          mux_out,
   output logic                      mux_valid,
   input  logic                      mux_ready,
   output logic [SEL_W-1:0]          grant_id,
   output logic                      sel_err
);
   logic [WIDTH-1:0] out_q, out_d;
   logic [SEL_W-1:0] gid_q, gid_d, ptr_q, ptr_d, gnt, rr_gnt;
   logic             val_q, val_d, err_q, err_d;
   logic             sel_ok, fixed_req, rr_any, any_grant, accept;
   logic [WIDTH-1:0] sel_data;

   rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_rr (
      .req(valid_in), .ptr(ptr_q), .gnt_idx(rr_gnt), .any_gnt(rr_any)
   );

   // Loops instead of direct indexing keep an out-of-range select from reading past valid_in.
   always_comb begin
      sel_ok    = int'(select) < CHANNELS;
      fixed_req = 1'b0;
      for (int i = 0; i < CHANNELS; i++)
         if (int'(select) == i) fixed_req = valid_in[i];
      gnt       = (arb_mode == MODE_RR) ? rr_gnt : select;
      any_grant = (arb_mode == MODE_RR) ? rr_any : (sel_ok && fixed_req);
      accept    = enable && (!val_q || mux_ready) && any_grant;
      sel_data  = '0;
      ready_out = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (int'(gnt) == i) sel_data = data_in[i*WIDTH +: WIDTH];
         ready_out[i] = accept && (int'(gnt) == i);
      end
   end

   always_comb begin
      out_d = out_q;
      gid_d = gid_q;
      val_d = val_q;
      ptr_d = ptr_q;
      err_d = (arb_mode == MODE_FIXED) && !sel_ok;
      if (accept) begin
         out_d = sel_data;
         gid_d = gnt;
         val_d = 1'b1;
         if (arb_mode == MODE_RR) ptr_d = gnt;
      end else if (enable && val_q && mux_ready) begin
         val_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         gid_q <= '0;
         val_q <= 1'b0;
         ptr_q <= SEL_W'(CHANNELS-1);
         err_q <= 1'b0;
      end else begin
         out_q <= out_d;
         gid_q <= gid_d;
         val_q <= val_d;
         ptr_q <= ptr_d;
         err_q <= err_d;
      end
   end

   assign mux_out   = enable ? out_q : {WIDTH{1'bz}};
   assign mux_valid = enable && val_q;
   assign grant_id  = gid_q;
   assign sel_err   = err_q;
endmodule

// File: tb/tb_mux_arb_n_w.sv
// Directed bench: stimulus pushes expected words, a monitor pops them on each consumed output.
module tb_mux_arb_n_w;
   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] data_in;
   logic [3:0]   valid_in, ready_out;
   logic [1:0]   select, grant_id;
   logic         arb_mode, enable, mux_valid, mux_ready, sel_err;
   wire  [31:0]  mux_out;

   logic [95:0]  data3;
   logic [2:0]   valid3, ready3;
   logic [1:0]   select3, gid3;
   logic         valid_o3, sel_err3;
   wire  [31:0]  mux_out3;

   typedef struct packed { logic [31:0] data; logic [1:0] gid; } exp_t;
   exp_t sb[$];
   int   n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   mux_arb_n_w #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
      .select(select), .arb_mode(arb_mode), .enable(enable), .mux_out(mux_out),
      .mux_valid(mux_valid), .mux_ready(mux_ready), .grant_id(grant_id), .sel_err(sel_err)
   );

   mux_arb_n_w #(.WIDTH(32), .CHANNELS(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst), .data_in(data3), .valid_in(valid3), .ready_out(ready3),
      .select(select3), .arb_mode(1'b0), .enable(1'b1), .mux_out(mux_out3),
      .mux_valid(valid_o3), .mux_ready(1'b1), .grant_id(gid3), .sel_err(sel_err3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int ch);
      return 32'hA5A5_0000 | 32'(ch);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch);
      exp_t e;
      e.data = word(ch);
      e.gid  = 2'(ch);
      sb.push_back(e);
   endtask

   // Each cycle the consumer takes a valid word, the oldest expected entry must match it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mux_valid && mux_ready) begin
            if (sb.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL sb_unexpected: got word %h with no entry expected", mux_out);
            end else begin
               e = sb.pop_front();
               check("sb_data", mux_out, e.data);
               check("sb_gid", 32'(grant_id), 32'(e.gid));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] z32, o;
      z32 = 'z;
      for (int i = 0; i < 4; i++) data_in[i*32 +: 32] = word(i);
      for (int i = 0; i < 3; i++) data3[i*32 +: 32] = 32'hC3C3_0000 | 32'(i);
      rst = 1'b1; valid_in = '0; select = '0; arb_mode = 1'b0; enable = 1'b1; mux_ready = 1'b0;
      valid3 = '0; select3 = '0;
      tick(); tick();
      check("rst_valid", 32'(mux_valid), 0);
      check("rst_gid", 32'(grant_id), 0);
      check("rst_out", mux_out, 0);
      check("rst_ready", 32'(ready_out), 0);
      check("rst_selerr", 32'(sel_err), 0);

      // Fixed select of channel 2
      rst = 1'b0; select = 2'd2; valid_in = 4'b0100; mux_ready = 1'b1;
      @(negedge clk); check("fix_ready", 32'(ready_out), 32'b0100); push(2);
      tick(); valid_in = '0;
      @(negedge clk); check("fix_valid", 32'(mux_valid), 1);
      tick();

      // Round-robin with all channels requesting
      arb_mode = 1'b1; valid_in = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); check("rr_ready", 32'(ready_out), 32'(1) << (k % 4)); push(k % 4);
         tick();
      end
      valid_in = '0;
      tick(); tick();

      // Back-pressure then release without a bubble
      valid_in = 4'b1111;
      @(negedge clk); check("bp_first", 32'(ready_out), 32'b0001); push(0);
      tick(); mux_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_ready", 32'(ready_out), 0);
         check("bp_hold_out", mux_out, word(0));
         check("bp_hold_gid", 32'(grant_id), 0);
         tick();
      end
      mux_ready = 1'b1;
      @(negedge clk); check("bp_nobubble", 32'(ready_out), 32'b0010); push(1);
      tick(); valid_in = '0;
      tick(); tick();

      // Disable with a held word
      valid_in = 4'b1111; mux_ready = 1'b0;
      @(negedge clk); check("en_grant", 32'(ready_out), 32'b0100); push(2);
      tick(); enable = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         o = mux_out;
         // A 2-state simulator resolves the undriven bus to 0 rather than z.
         n_chk++;
         if (o !== z32 && o !== 32'h0) begin
            n_err++;
            $display("FAIL en_tristate: got %h expected zzzzzzzz", o);
         end
         check("en_valid", 32'(mux_valid), 0);
         check("en_ready", 32'(ready_out), 0);
         tick();
      end
      enable = 1'b1; mux_ready = 1'b1; valid_in = '0;
      @(negedge clk); check("en_back", 32'(mux_valid), 1);
      tick(); tick();

      // Out-of-range select on the 3-channel instance
      select3 = 2'd3; valid3 = 3'b111;
      @(negedge clk); check("se_ready", 32'(ready3), 0); check("se_pre", 32'(sel_err3), 0);
      tick(); select3 = 2'd0; valid3 = '0;
      @(negedge clk); check("se_pulse", 32'(sel_err3), 1); check("se_valid", 32'(valid_o3), 0);
      tick();
      @(negedge clk); check("se_clear", 32'(sel_err3), 0); check("se_valid2", 32'(valid_o3), 0);

      // Asynchronous reset mid-stream
      tick(); valid_in = 4'b1111;
      @(posedge clk); #3;
      check("ar_pre_valid", 32'(mux_valid), 1);
      rst = 1'b1; #1;
      check("ar_valid", 32'(mux_valid), 0);
      check("ar_gid", 32'(grant_id), 0);
      check("ar_out", mux_out, 0);
      sb.delete();
      tick(); rst = 1'b0;
      @(negedge clk); check("ar_first", 32'(ready_out), 32'b0001); push(0);
      tick(); valid_in = '0;
      tick(); tick();
      check("sb_drained", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
